instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 111 +++++++++++
 tb/tb_instruction_fetch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Purpose: fetches one instruction per entry into the fetch phase and holds it in the IR.
// Latency: mem_req rises one cycle after fetch entry; IR updates one cycle after ack or timeout.
// Backpressure: stall holds the phase sequencer while a request is outstanding or being launched.
module instruction_fetch #(
    parameter logic [2:0]  FETCH_PHASE = 3'b000,
    parameter int          TIMEOUT     = 8,
    parameter logic [15:0] NOP_WORD    = 16'h0000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [2:0]  phase,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    output logic        stall,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value before the request is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  phase_q;
    logic [7:0]  tmo_cnt;
    logic        fetch_start;
    logic        tmo_hit;

    // Fetch launches only on the edge into the fetch phase, so a held phase never refetches.
    always_comb begin
        fetch_start = (phase == FETCH_PHASE) && (phase_q != FETCH_PHASE) && (state == IDLE);
        tmo_hit     = (tmo_cnt == TMO_LAST);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ack takes precedence over timeout, both end the request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fetch_start)             state_nxt = BUSY;
            BUSY: if (mem_ack || tmo_hit)      state_nxt = DONE;
            DONE: if (phase != FETCH_PHASE)    state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Stall covers the launch cycle as well as the whole outstanding request.
    always_comb begin
        stall = (state == BUSY) || fetch_start;
    end

    // Request, address, IR and error registers; acks outside BUSY are ignored.
    always_ff @(posedge clock) begin
        if (rst) begin
            phase_q   <= 3'b111;
            mem_req   <= 1'b0;
            mem_addr  <= 16'h0000;
            ir_out    <= 16'h0000;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            tmo_cnt   <= 8'd0;
        end else begin
            phase_q <= phase;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        mem_addr <= pc_in;
                        mem_req  <= 1'b1;
                        ir_valid <= 1'b0;
                        tmo_cnt  <= 8'd0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        ir_out   <= mem_rdata;
                        ir_valid <= 1'b1;
                        mem_req  <= 1'b0;
                    end else if (tmo_hit) begin
                        ir_out    <= NOP_WORD;
                        ir_valid  <= 1'b1;
                        fetch_err <= 1'b1;
                        mem_req   <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of per-cycle vectors plus multi-cycle corner cases.
// Inputs are driven on the falling edge and outputs compared 1ns later.
// Covers reset, normal fetch, timeout, ack/timeout collision, phase hold and abort by reset.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        rst;
    logic [2:0]  phase;
    logic [15:0] pc_in;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        stall;
    logic        fetch_err;

    int n_chk  = 0;
    int n_fail = 0;

    instruction_fetch #(
        .FETCH_PHASE (3'b000),
        .TIMEOUT     (8),
        .NOP_WORD    (16'h0000)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .phase     (phase),
        .pc_in     (pc_in),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .stall     (stall),
        .fetch_err (fetch_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        r;
        logic [2:0]  ph;
        logic [15:0] pc;
        logic [15:0] rd;
        logic        ack;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_ir;
        logic        e_vld;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    vec_t tbl [15];

    task automatic drive(input logic r, input logic [2:0] ph, input logic [15:0] pc,
                         input logic [15:0] rd, input logic ack);
        @(negedge clock);
        rst = r; phase = ph; pc_in = pc; mem_rdata = rd; mem_ack = ack;
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                           input logic [15:0] ir, input logic vld, input logic stl, input logic err);
        chk({tag, ".mem_req"},   16'(mem_req),   16'(req));
        chk({tag, ".mem_addr"},  mem_addr,       addr);
        chk({tag, ".ir_out"},    ir_out,         ir);
        chk({tag, ".ir_valid"},  16'(ir_valid),  16'(vld));
        chk({tag, ".stall"},     16'(stall),     16'(stl));
        chk({tag, ".fetch_err"}, 16'(fetch_err), 16'(err));
    endtask

    initial begin
        int cnt;
        // r  ph    pc        rd        ack | req addr      ir        vld stl err
        tbl[0]  = '{1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 16'h0012, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 16'h0055, 16'h0000, 1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 16'h0066, 16'h0000, 1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 16'h0077, 16'h0000, 1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 16'h0088, 16'hA5C3, 1'b1, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 16'h0088, 16'h0000, 1'b0, 1'b0, 16'h0012, 16'hA5C3, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 16'h0088, 16'hFFFF, 1'b1, 1'b0, 16'h0012, 16'hA5C3, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 3'd5, 16'h0088, 16'h0000, 1'b0, 1'b0, 16'h0012, 16'hA5C3, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 3'd5, 16'h0088, 16'h7777, 1'b1, 1'b0, 16'h0012, 16'hA5C3, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 3'd5, 16'h0088, 16'h0000, 1'b0, 1'b0, 16'h0012, 16'hA5C3, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; phase = 3'd5; pc_in = 16'h0000; mem_rdata = 16'h0000; mem_ack = 1'b0;
        drive(1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0);

        // Per-cycle vectors: reset, fetch at release, 3-cycle-latency fetch, spurious acks.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r, tbl[i].ph, tbl[i].pc, tbl[i].rd, tbl[i].ack);
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_ir,
                    tbl[i].e_vld, tbl[i].e_stall, tbl[i].e_err);
        end

        // Timeout: no ack, request must last exactly 8 cycles.
        drive(1'b0, 3'd0, 16'h0020, 16'h0000, 1'b0);
        chk("tmo.launch_stall", 16'(stall), 16'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 3'd0, 16'h0020, 16'h0000, 1'b0);
            if (!mem_req) break;
            cnt++;
        end
        chk("tmo.req_cycles", 16'(cnt), 16'd8);
        chk_all("tmo.done", 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1);
        // Next fetch succeeds; sticky error remains.
        drive(1'b0, 3'd5, 16'h0021, 16'h0000, 1'b0);
        drive(1'b0, 3'd0, 16'h0021, 16'h0000, 1'b0);
        drive(1'b0, 3'd0, 16'h0021, 16'h4321, 1'b1);
        chk("tmo2.mem_addr", mem_addr, 16'h0021);
        drive(1'b0, 3'd0, 16'h0021, 16'h0000, 1'b0);
        chk_all("tmo2.done", 1'b0, 16'h0021, 16'h4321, 1'b1, 1'b0, 1'b1);

        // Ack on the final timeout cycle: data wins, no error.
        drive(1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, 3'd0, 16'h0030, 16'h0000, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 3'd0, 16'h0030, 16'h0000, 1'b0);
        chk("coin.req_still_high", 16'(mem_req), 16'd1);
        drive(1'b0, 3'd0, 16'h0030, 16'h1234, 1'b1);
        drive(1'b0, 3'd0, 16'h0030, 16'h0000, 1'b0);
        chk_all("coin.done", 1'b0, 16'h0030, 16'h1234, 1'b1, 1'b0, 1'b0);

        // Phase held in fetch phase: no further request.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 3'd0, 16'h0031, 16'h0000, 1'b0);
            if (mem_req || stall) cnt++;
        end
        chk("hold.no_refetch", 16'(cnt), 16'd0);
        drive(1'b0, 3'd5, 16'h0013, 16'h0000, 1'b0);
        drive(1'b0, 3'd0, 16'h0013, 16'h0000, 1'b0);
        chk("refetch.stall", 16'(stall), 16'd1);
        drive(1'b0, 3'd0, 16'h0013, 16'h5A5A, 1'b1);
        chk("refetch.mem_req", 16'(mem_req), 16'd1);
        chk("refetch.mem_addr", mem_addr, 16'h0013);
        drive(1'b0, 3'd0, 16'h0013, 16'h0000, 1'b0);
        chk_all("refetch.done", 1'b0, 16'h0013, 16'h5A5A, 1'b1, 1'b0, 1'b0);

        // Reset mid-request, then a late ack that must be ignored.
        drive(1'b0, 3'd5, 16'h0040, 16'h0000, 1'b0);
        drive(1'b0, 3'd0, 16'h0040, 16'h0000, 1'b0);
        drive(1'b1, 3'd0, 16'h0040, 16'h0000, 1'b0);
        chk("abort.req_before", 16'(mem_req), 16'd1);
        drive(1'b0, 3'd5, 16'h0040, 16'h9999, 1'b1);
        chk_all("abort.reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd5, 16'h0040, 16'h0000, 1'b0);
        chk_all("abort.late_ack", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
